// File: rtl/mem_sequencer.sv
// rtl/mem_sequencer.sv - i/j/n address sequencer and delayed output-memory write-back for the Memory stage
// Optional macro MEM_SEQ_PERF_CNT_EN adds perf_cycles/perf_stalls counters.
module mem_sequencer #(
  parameter int DATA_W   = 32,
  parameter int LANES    = 4,
  parameter int PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] n_in,
  input  logic              stall,
  output logic [DATA_W-1:0] i,
  output logic [DATA_W-1:0] j,
  output logic [DATA_W-1:0] n,
  output logic [DATA_W-1:0] wom_addr,
  output logic              wr_wom,
  output logic              busy,
  output logic              done
`ifdef MEM_SEQ_PERF_CNT_EN
  ,
  output logic [DATA_W-1:0] perf_cycles,
  output logic [DATA_W-1:0] perf_stalls
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t state, state_nx;

  logic [DATA_W-1:0] grp;
  logic [DATA_W:0]   j_sum;
  logic              row_end;
  logic              last_grp;
  logic              accept;
  logic              push;
  logic              pre_tail_empty;

  logic              dl_vld [PIPE_LAT];
  logic [DATA_W-1:0] dl_tag [PIPE_LAT];

  // Row/frame end detection; the sum is one bit wider so a large n cannot wrap it.
  always_comb begin
    j_sum    = {1'b0, j} + (DATA_W + 1)'(LANES);
    row_end  = (j_sum >= {1'b0, n});
    last_grp = row_end && (i == (n - DATA_W'(1)));
  end

  // Everything ahead of the tail is empty, so one more shift drains the line.
  always_comb begin
    pre_tail_empty = 1'b1;
    for (int k = 0; k < PIPE_LAT - 1; k++) begin
      if (dl_vld[k]) begin
        pre_tail_empty = 1'b0;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic and status outputs; start is only honoured from IDLE.
  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    push     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept   = 1'b1;
          state_nx = (n_in == '0) ? S_FLUSH : S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy = 1'b1;
        if (!stall) begin
          push = 1'b1;
          if (last_grp) begin
            state_nx = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        busy = 1'b1;
        if (!stall && pre_tail_empty) begin
          state_nx = S_DONE;
        end
      end
      S_DONE: begin
        done     = 1'b1;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Index walk: j steps by LANES across a row, then wraps and bumps i; the last pair is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      i   <= '0;
      j   <= '0;
      n   <= '0;
      grp <= '0;
    end else if (accept) begin
      n   <= n_in;
      i   <= '0;
      j   <= '0;
      grp <= '0;
    end else if (push && !last_grp) begin
      grp <= grp + DATA_W'(1);
      if (row_end) begin
        j <= '0;
        i <= i + DATA_W'(1);
      end else begin
        j <= j + DATA_W'(LANES);
      end
    end
  end

  // Latency-matching token chain; tags only move with a valid token so the tail tag holds between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < PIPE_LAT; k++) begin
        dl_vld[k] <= 1'b0;
        dl_tag[k] <= '0;
      end
    end else if (!stall) begin
      dl_vld[0] <= push;
      if (push) begin
        dl_tag[0] <= grp;
      end
      for (int k = 1; k < PIPE_LAT; k++) begin
        dl_vld[k] <= dl_vld[k-1];
        if (dl_vld[k-1]) begin
          dl_tag[k] <= dl_tag[k-1];
        end
      end
    end
  end

  assign wr_wom   = dl_vld[PIPE_LAT-1] && !stall;
  assign wom_addr = dl_tag[PIPE_LAT-1];

`ifdef MEM_SEQ_PERF_CNT_EN
  // Busy-cycle and stalled-busy-cycle counters, restarted by each accepted start.
  always_ff @(posedge clk) begin
    if (rst || accept) begin
      perf_cycles <= '0;
      perf_stalls <= '0;
    end else if (busy) begin
      perf_cycles <= perf_cycles + DATA_W'(1);
      if (stall) begin
        perf_stalls <= perf_stalls + DATA_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_sequencer.sv
// tb/tb_mem_sequencer.sv - scoreboard bench for mem_sequencer
module tb_mem_sequencer;

  localparam int DW = 32;
  localparam int LN = 4;
  localparam int PL = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [DW-1:0] n_in;
  logic          stall;
  logic [DW-1:0] i, j, n, wom_addr;
  logic          wr_wom, busy, done;
`ifdef MEM_SEQ_PERF_CNT_EN
  logic [DW-1:0] perf_cycles, perf_stalls;
`endif

  mem_sequencer #(.DATA_W(DW), .LANES(LN), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .start(start), .n_in(n_in), .stall(stall),
    .i(i), .j(j), .n(n), .wom_addr(wom_addr), .wr_wom(wr_wom),
    .busy(busy), .done(done)
`ifdef MEM_SEQ_PERF_CNT_EN
    , .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int t0 = 0;
  int checks = 0;
  int failures = 0;

  typedef struct {
    int addr;
    int cyc;
  } wr_t;

  wr_t wq[$];
  int  dq[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string nm, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (rel cycle %0d)", nm, act, exp, cyc - t0);
    end
  endfunction

  // Monitor: pops the expected write/done whenever the DUT presents one.
  always @(negedge clk) begin
    int  rel;
    int  ed;
    wr_t e;
    rel = cyc - t0;
    if (wr_wom) begin
      if (wq.size() == 0) begin
        chk("wr_unexpected", longint'(wom_addr), -1);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", longint'(wom_addr), e.addr);
        chk("wr_cycle", rel, e.cyc);
      end
    end
    if (done) begin
      if (dq.size() == 0) begin
        chk("done_unexpected", rel, -1);
      end else begin
        ed = dq.pop_front();
        if (ed < 0) chk("done_window", (rel <= PL + 2) ? 1 : 0, 1);
        else        chk("done_cycle", rel, ed);
      end
    end
  end

  task automatic check_zero(string tag);
    chk({tag, "_i"}, i, 0);
    chk({tag, "_j"}, j, 0);
    chk({tag, "_n"}, n, 0);
    chk({tag, "_wom_addr"}, wom_addr, 0);
    chk({tag, "_wr_wom"}, wr_wom, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  // One frame: ss/sl = stall window, rs_rel = extra start pulse, rst_rel = reset cycle (0 = none).
  task automatic frame(input int nn, input int ss, input int sl, input int rs_rel,
                       input int rst_rel, input int ncyc);
    int  gpr, g_tot, d, c, g, busy_cnt;
    wr_t e;
    gpr   = (nn + LN - 1) / LN;
    g_tot = nn * gpr;
    d     = 1 + g_tot + PL + sl;
    for (int k = 0; k < g_tot; k++) begin
      c = 1 + k + PL;
      if (sl > 0 && c >= ss) c += sl;
      if (rst_rel == 0 || c <= rst_rel) begin
        e.addr = k;
        e.cyc  = c;
        wq.push_back(e);
      end
    end
    if (rst_rel == 0) dq.push_back((nn == 0) ? -1 : d);
    busy_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1;
    n_in  = DW'(nn);
    t0    = cyc;
    for (int r = 1; r <= ncyc; r++) begin
      @(posedge clk); #1;
      start = (r == rs_rel);
      n_in  = DW'(nn + 3 + r);
      stall = (sl > 0 && r >= ss && r < ss + sl);
      rst   = (r == rst_rel);
      @(negedge clk);
      if (rst_rel > 0 && r == rst_rel + 1) begin
        check_zero("post_rst");
      end else if (rst_rel == 0 || r <= rst_rel) begin
        if (nn == 0) begin
          busy_cnt += int'(busy);
          chk("n0_i", i, 0);
          chk("n0_j", j, 0);
        end else begin
          chk("busy", busy, (r < d) ? 1 : 0);
          chk("n_latched", n, nn);
          if (r < d) begin
            if (sl > 0 && r >= ss) g = (r < ss + sl) ? ss - 1 : r - 1 - sl;
            else                   g = r - 1;
            if (g > g_tot - 1) g = g_tot - 1;
            chk("i", i, g / gpr);
            chk("j", j, (g % gpr) * LN);
          end
        end
      end
    end
    start = 1'b0;
    stall = 1'b0;
    rst   = 1'b0;
    if (nn == 0) begin
      chk("n0_busy_max", (busy_cnt <= PL + 1) ? 1 : 0, 1);
      chk("n0_busy_min", (busy_cnt >= 1) ? 1 : 0, 1);
    end
    chk("wr_queue_empty", wq.size(), 0);
    chk("done_queue_empty", dq.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    n_in  = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");

    frame(4, 0, 0, 3, 0, 10);
`ifdef MEM_SEQ_PERF_CNT_EN
    chk("perf_cycles_n4", perf_cycles, 6);
    chk("perf_stalls_n4", perf_stalls, 0);
`endif
    frame(5, 0, 0, 13, 0, 16);
    frame(8, 5, 3, 0, 0, 25);
`ifdef MEM_SEQ_PERF_CNT_EN
    chk("perf_cycles_n8s", perf_cycles, 21);
    chk("perf_stalls_n8s", perf_stalls, 3);
`endif
    frame(0, 0, 0, 0, 0, 8);
    frame(8, 0, 0, 0, 4, 10);
    frame(4, 0, 0, 0, 0, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
